commit_trace_sequencer: RTL and testbench

//  Collects up to NCH retire records per cycle from the superscalar commit port and buffers them.

---
 rtl/commit_trace_pkg.sv | 33 +++
 rtl/commit_compact.sv | 32 +++
 rtl/commit_trace_sequencer.sv | 140 ++++++++++++++
 tb/tb_commit_trace_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace sequencer: the retire record layout,
// the halt-instruction encodings and the halt classifier.
package commit_trace_pkg;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst;
        logic [63:0] pc_rdata;
        logic [63:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
    } commit_rec_t;

    localparam int REC_W = $bits(commit_rec_t);

    localparam logic [31:0] HALT_BEQ  = 32'h0000_0063;
    localparam logic [31:0] HALT_JAL  = 32'h0000_006f;
    localparam logic [31:0] HALT_SLTI = 32'hF000_2013;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_e;

    // A self-loop (pc unchanged) or one of the known halt idioms ends the run.
    function automatic logic is_halt(input commit_rec_t rec);
        return (rec.pc_rdata == rec.pc_wdata) ||
               (rec.inst == HALT_BEQ) ||
               (rec.inst == HALT_JAL) ||
               (rec.inst == HALT_SLTI);
    endfunction

endpackage

// File: rtl/commit_compact.sv
// Combinational prefix compaction of the per-channel retire valids: length of
// the contiguous run from channel 0, plus the full popcount for hole detection.
module commit_compact #(
    parameter int NCH   = 8,
    parameter int CNT_W = $clog2(NCH) + 1
) (
    input  logic [NCH-1:0]   in_valid,
    output logic [CNT_W-1:0] prefix_len,
    output logic [CNT_W-1:0] pop_cnt
);

    logic in_run;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    always_comb begin
        prefix_len = '0;
        pop_cnt    = '0;
        in_run     = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i]) begin
                pop_cnt = pop_cnt + CNT_W'(1);
            end
            if (in_run && in_valid[i]) begin
                prefix_len = prefix_len + CNT_W'(1);
            end else begin
                in_run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/commit_trace_sequencer.sv
// Buffers up to NCH retire records per cycle and replays them one per cycle in
// retire order, checking order continuity and stopping on the halt record.
module commit_trace_sequencer
    import commit_trace_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*REC_W-1:0] in_rec,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REC_W-1:0]     out_rec,
    output logic                 halted,
    output logic                 order_err,
    output logic [63:0]          cnt_emit
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(NCH) + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] NCH_P   = PTR_W'(NCH);

    seq_state_e       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic [63:0]      exp_order_q, exp_order_d;
    logic [63:0]      cnt_emit_q, cnt_emit_d;
    logic             order_err_q, order_err_d;

    commit_rec_t      mem_q [DEPTH];
    commit_rec_t      chan_rec [NCH];
    commit_rec_t      head_rec;

    logic [CNT_W-1:0] prefix_len;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] push_len;
    logic             push;
    logic             pop;
    logic             hole;

    commit_compact #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_compact (
        .in_valid   (in_valid),
        .prefix_len (prefix_len),
        .pop_cnt    (pop_cnt)
    );

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            chan_rec[i] = in_rec[i*REC_W +: REC_W];
        end
    end

    // in_ready is gated by rst_n so the producer sees no acceptance during reset.
    assign in_ready  = rst_n && (state_q == ST_RUN) && ((DEPTH_P - count_q) >= NCH_P);
    assign out_valid = (count_q != '0) && (state_q == ST_RUN);
    assign head_rec  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign out_rec   = head_rec;
    assign halted    = (state_q == ST_HALTED);
    assign order_err = order_err_q;
    assign cnt_emit  = cnt_emit_q;

    assign push     = in_ready && (|in_valid);
    assign pop      = out_valid && out_ready;
    assign hole     = (pop_cnt != prefix_len);
    assign push_len = push ? prefix_len : '0;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        exp_order_d = exp_order_q;
        cnt_emit_d  = cnt_emit_q;
        order_err_d = order_err_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_len);
        count_d     = count_q + PTR_W'(push_len) - PTR_W'(pop);

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            cnt_emit_d  = cnt_emit_q + 64'd1;
            // Resync on every pop so one gap reports once, not on every later record.
            exp_order_d = head_rec.order + 64'd1;
            if (head_rec.order != exp_order_q) begin
                order_err_d = 1'b1;
            end
            if (is_halt(head_rec)) begin
                state_d = ST_HALTED;
            end
        end

        if (push && hole) begin
            order_err_d = 1'b1;
        end

        // Anything still buffered (including a same-cycle group) dies with the halt.
        if (state_d == ST_HALTED) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exp_order_q <= '0;
            cnt_emit_q  <= '0;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exp_order_q <= exp_order_d;
            cnt_emit_q  <= cnt_emit_d;
            order_err_q <= order_err_d;
        end
    end

    // NOTE: the record store has no reset; count_q gates every read, so stale
    // contents are never observable and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push && (CNT_W'(i) < prefix_len)) begin
                mem_q[wr_ptr_q[IDX_W-1:0] + IDX_W'(i)] <= chan_rec[i];
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_sequencer.sv
// Directed bench for commit_trace_sequencer: a scoreboard queue of expected
// orders is filled on accepted groups and drained as records are emitted.
module tb_commit_trace_sequencer;
    import commit_trace_pkg::*;

    localparam int NCH   = 8;
    localparam int DEPTH = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       in_valid;
    logic [NCH*REC_W-1:0] in_rec;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [REC_W-1:0]     out_rec;
    logic                 halted;
    logic                 order_err;
    logic [63:0]          cnt_emit;

    commit_rec_t chan [NCH];
    commit_rec_t out_r;
    logic [63:0] exp_q [$];
    int          total;
    int          bad;

    commit_trace_sequencer #(
        .NCH   (NCH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_rec    (in_rec),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .halted    (halted),
        .order_err (order_err),
        .cnt_emit  (cnt_emit)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign in_rec[g*REC_W +: REC_W] = chan[g];
    end
    assign out_r = out_rec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic commit_rec_t mk_rec(input logic [63:0] order, input logic [31:0] inst);
        commit_rec_t r;
        r.order    = order;
        r.inst     = inst;
        r.pc_rdata = 64'h1000 + (order << 2);
        r.pc_wdata = 64'h1004 + (order << 2);
        r.rd_addr  = order[4:0];
        r.rd_wdata = ~order;
        return r;
    endfunction

    function automatic int pre_len(input logic [NCH-1:0] v);
        int  n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (run && v[i]) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    task automatic set_group(input int n, input logic [63:0] base, input logic [31:0] inst0);
        for (int i = 0; i < NCH; i++) begin
            chan[i]     = mk_rec(base + 64'(i), (i == 0) ? inst0 : NOP);
            in_valid[i] = (i < n);
        end
    endtask

    // One clock: score the handshakes about to happen, then advance to the next negedge.
    task automatic cyc();
        if (in_ready && (in_valid != '0)) begin
            for (int i = 0; i < pre_len(in_valid); i++) exp_q.push_back(chan[i].order);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL pop_unexpected observed=%0h expected=none", out_r.order);
                end
            end else begin
                check("pop_order", out_r.order, exp_q.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        in_valid  = '0;
        for (int i = 0; i < NCH; i++) chan[i] = mk_rec(64'(i), NOP);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_order_err", order_err, 0);
        check("rst_cnt_emit", cnt_emit, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // 1: three channels, replayed on three consecutive cycles
        @(negedge clk);
        out_ready = 1'b1;
        set_group(3, 64'd0, NOP);
        cyc();
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            check("t1_out_valid", out_valid, 1);
            cyc();
        end
        check("t1_cnt_emit", cnt_emit, 3);
        check("t1_order_err", order_err, 0);
        check("t1_empty", out_valid, 0);

        // 2: fill to full with the consumer stalled, then drain across the wrap
        out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check("t2_in_ready_open", in_ready, 1);
            set_group(8, 64'(3 + 8 * g), NOP);
            cyc();
        end
        check("t2_in_ready_full", in_ready, 0);
        check("t2_out_valid_full", out_valid, 1);
        set_group(8, 64'd35, NOP);
        cyc();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) cyc();
        check("t2_drained", out_valid, 0);
        check("t2_cnt_emit", cnt_emit, 35);
        check("t2_order_err", order_err, 0);

        // 5: hole in in_valid keeps only the channel-0 record
        set_group(3, 64'd35, NOP);
        in_valid = 8'b0000_0101;
        cyc();
        in_valid = '0;
        check("t5_order_err", order_err, 1);
        cyc();
        check("t5_empty", out_valid, 0);
        check("t5_cnt_emit", cnt_emit, 36);

        // 6: asynchronous reset with ten records buffered
        out_ready = 1'b0;
        set_group(8, 64'd36, NOP);
        cyc();
        set_group(2, 64'd44, NOP);
        cyc();
        in_valid  = '0;
        out_ready = 1'b1;
        check("t6_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_ready", in_ready, 0);
        check("t6_async_cnt", cnt_emit, 0);
        check("t6_async_err", order_err, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_rel_valid", out_valid, 0);
        check("t6_rel_cnt", cnt_emit, 0);
        check("t6_rel_halted", halted, 0);
        check("t6_rel_ready", in_ready, 1);
        @(negedge clk);

        // 3: order gap 0 -> 2 flags at the pop of 2; 3 continues from the resync
        set_group(3, 64'd0, NOP);
        chan[1] = mk_rec(64'd2, NOP);
        chan[2] = mk_rec(64'd3, NOP);
        cyc();
        in_valid = '0;
        cyc();
        check("t3_err_before", order_err, 0);
        cyc();
        check("t3_err_after", order_err, 1);
        cyc();
        check("t3_cnt_emit", cnt_emit, 3);

        // 4: halt at order 10; 11, 12 and a same-cycle group are flushed
        set_group(3, 64'd10, HALT_JAL);
        cyc();
        set_group(1, 64'd13, NOP);
        check("t4_ready_at_halt", in_ready, 1);
        check("t4_head_valid", out_valid, 1);
        cyc();
        in_valid = '0;
        check("t4_halted", halted, 1);
        check("t4_out_valid", out_valid, 0);
        check("t4_in_ready", in_ready, 0);
        check("t4_cnt_emit", cnt_emit, 4);
        exp_q.delete();
        repeat (3) cyc();
        check("t4_still_halted", halted, 1);
        check("t4_no_more", cnt_emit, 4);
        check("t4_stay_quiet", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
